channel_buffer_reader: RTL and testbench

Read-side controller for the dual-width channel buffer BRAM. After a 16-bit writer has filled a frame of sample slots, this block reads a programmed run of 256-bit words from the BRAM's wide read port. It absorbs the BRAM's fixed read latency and delivers each word to the downstream packet/processing stage over a valid/ready stream. Reads are issued with credit-based flow control, so no word is lost under backpressure.

---
 rtl/channel_buffer_pkg.sv | 16 +
 rtl/channel_buffer_reader_if.sv | 24 ++
 rtl/channel_buffer_word_fifo.sv | 52 +++++
 rtl/channel_buffer_reader.sv | 125 ++++++++++++
 tb/tb_channel_buffer_reader.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/channel_buffer_pkg.sv
// Shared constants and state encoding for the dual-width channel buffer.
// The writer side and the read-side controller both use this package.
package channel_buffer_pkg;

  localparam int DATA_WIDTH = 256;
  localparam int ADDR_WIDTH = 7;
  localparam int RD_LATENCY = 2;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/channel_buffer_reader_if.sv
// BRAM wide read port plus downstream valid/ready stream, seen from the reader.
interface channel_buffer_reader_if #(
  parameter int DATA_WIDTH = channel_buffer_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = channel_buffer_pkg::ADDR_WIDTH
);

  logic [ADDR_WIDTH-1:0] bram_rdaddress;
  logic                  bram_rden;
  logic [DATA_WIDTH-1:0] bram_q;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output bram_rdaddress, bram_rden, out_data, out_valid,
    input  bram_q, out_ready
  );

  modport slave (
    input  bram_rdaddress, bram_rden, out_data, out_valid,
    output bram_q, out_ready
  );

endinterface

// File: rtl/channel_buffer_word_fifo.sv
// Show-ahead word FIFO: rd_data is the head entry whenever empty is low.
module channel_buffer_word_fifo #(
  parameter int DATA_WIDTH = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic                             rd_en,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count,
  output logic                             empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
      unique case ({wr_en, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/channel_buffer_reader.sv
// Reads a run of wide words from the channel buffer BRAM and streams them out,
// issuing reads only while the word FIFO has room for everything in flight.
module channel_buffer_reader #(
  parameter int DATA_WIDTH = channel_buffer_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = channel_buffer_pkg::ADDR_WIDTH,
  parameter int RD_LATENCY = channel_buffer_pkg::RD_LATENCY,
  parameter int FIFO_DEPTH = channel_buffer_pkg::FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic [ADDR_WIDTH:0]     word_count,
  output logic                    busy,
  output logic                    done,
  channel_buffer_reader_if.master bus
);

  import channel_buffer_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IFL_W = $clog2(RD_LATENCY + 1);
  localparam int RUN_W = ADDR_WIDTH + 1;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_en;
  logic [RUN_W-1:0]      remaining;
  logic [RD_LATENCY-1:0] vld_p;
  logic [IFL_W-1:0]      in_flight;
  logic                  done_q;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;

  logic accept, accept_run, issue, credit_ok, land, pop, drain_done;

  assign land       = vld_p[RD_LATENCY-1];
  assign pop        = !fifo_empty && bus.out_ready;
  // Current count only: a credit freed by this cycle's pop is seen next cycle.
  assign credit_ok  = (int'(in_flight) + int'(fifo_count)) < FIFO_DEPTH;
  assign drain_done = (in_flight == '0) && (fifo_count == CNT_W'(pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start && word_count != '0)
                 state_nxt = (word_count == RUN_W'(1)) ? DRAIN : READ;
      READ:    if (credit_ok && remaining == RUN_W'(1)) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    accept     = 1'b0;
    accept_run = 1'b0;
    issue      = 1'b0;
    unique case (state)
      IDLE: begin
        accept     = start;
        accept_run = start && (word_count != '0);
        issue      = accept_run;
      end
      READ: begin
        busy  = 1'b1;
        issue = credit_ok;
      end
      DRAIN:   busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // p0: read issue register; vld_p tracks each read until bram_q carries it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      remaining <= '0;
      vld_p     <= '0;
      in_flight <= '0;
      done_q    <= 1'b0;
    end else begin
      rd_en <= issue;
      if (accept_run) begin
        rd_addr   <= start_addr;
        remaining <= word_count - RUN_W'(1);
      end else if (issue) begin
        rd_addr   <= rd_addr + ADDR_WIDTH'(1);
        remaining <= remaining - RUN_W'(1);
      end
      vld_p     <= (vld_p << 1) | RD_LATENCY'(issue);
      in_flight <= in_flight + IFL_W'(issue) - IFL_W'(land);
      done_q    <= (accept && word_count == '0) || (state == DRAIN && drain_done);
    end
  end

  // p<RD_LATENCY>: landed word enters the FIFO
  channel_buffer_word_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (land),
    .wr_data (bus.bram_q),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  assign bus.bram_rden      = rd_en;
  assign bus.bram_rdaddress = rd_addr;
  assign bus.out_valid      = !fifo_empty;
  assign bus.out_data       = fifo_empty ? '0 : fifo_head;
  assign done               = done_q;

endmodule

// File: tb/tb_channel_buffer_reader.sv
// Bench for channel_buffer_reader: behavioural BRAM, stream monitor and
// expected word order/timing derived from the run parameters.
module tb_channel_buffer_reader;

  import channel_buffer_pkg::*;

  localparam int DW     = DATA_WIDTH;
  localparam int AW     = ADDR_WIDTH;
  localparam int CW     = ADDR_WIDTH + 1;
  localparam int LAT    = RD_LATENCY;
  localparam int DEPTH  = FIFO_DEPTH;
  localparam int NWORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [CW-1:0] word_count = '0;
  logic          busy;
  logic          done;

  channel_buffer_reader_if bif ();

  channel_buffer_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .bus        (bif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: the reader's registered rden/rdaddress is the first latency stage
  logic [DW-1:0] mem [NWORDS];
  logic [DW-1:0] q_pipe [LAT-1];
  always @(posedge clk) begin
    if (bif.bram_rden) q_pipe[0] <= mem[bif.bram_rdaddress];
    for (int i = 1; i < LAT - 1; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign bif.bram_q = q_pipe[LAT-2];

  logic [DW-1:0] got_q[$];
  int            got_cyc_q[$];
  int            rd_q[$];
  int            done_cnt = 0;
  int            done_cyc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bif.out_valid && bif.out_ready) begin
        got_q.push_back(bif.out_data);
        got_cyc_q.push_back(cyc);
      end
      if (bif.bram_rden) rd_q.push_back(int'(bif.bram_rdaddress));
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int k);
    logic [15:0] h;
    h = 16'(k);
    return {16{h}};
  endfunction

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_busy"},  busy, 0);
    chk({pfx, "_done"},  done, 0);
    chk({pfx, "_rden"},  bif.bram_rden, 0);
    chk({pfx, "_addr"},  bif.bram_rdaddress, 0);
    chk({pfx, "_valid"}, bif.out_valid, 0);
    chk({pfx, "_data"},  bif.out_data, 0);
  endtask

  // mode: 0 ready high, 1 ready low for 20 cycles, 2 toggling, 3 random
  task automatic do_run(input int sa, input int n, input int mode, input bit restart);
    int rd_base, got_base, done_base, e, c, max_out, rel_rd, outst, seen_c, a;
    bit seen_done;
    rd_base   = rd_q.size();
    got_base  = got_q.size();
    done_base = done_cnt;
    max_out   = 0;
    rel_rd    = -1;
    seen_done = 1'b0;
    seen_c    = 0;
    @(posedge clk); #1;
    start         = 1'b1;
    start_addr    = AW'(sa);
    word_count    = CW'(n);
    bif.out_ready = (mode == 0) || (mode == 2) || (mode == 3);
    e = cyc;
    for (c = 0; c < n * 4 + 60; c++) begin
      @(posedge clk); #1;
      start = restart && (c == 2);
      if (restart && c == 2) begin
        start_addr = AW'(sa + 50);
        word_count = CW'(3);
      end
      case (mode)
        1: begin
          if (c == 20) rel_rd = rd_q.size() - rd_base;
          bif.out_ready = (c >= 20);
        end
        2:       bif.out_ready = (c % 2 == 1);
        3:       bif.out_ready = ($urandom_range(0, 3) != 0);
        default: bif.out_ready = 1'b1;
      endcase
      @(negedge clk); #1;
      outst = (rd_q.size() - rd_base) - (got_q.size() - got_base);
      if (outst > max_out) max_out = outst;
      if (c == 0) begin
        if (n == 0) begin
          chk("zero_busy", busy, 0);
          chk("zero_done", done, 1);
        end else begin
          chk("first_busy", busy, 1);
          chk("first_rden", bif.bram_rden, 1);
          chk("first_addr", bif.bram_rdaddress, sa % NWORDS);
        end
      end
      if (done && !seen_done) begin
        seen_done = 1'b1;
        seen_c    = c;
        chk("busy_at_done", busy, 0);
      end
      if (seen_done && c >= seen_c + 3) break;
    end
    chk("done_once", done_cnt - done_base, 1);
    chk("word_total", got_q.size() - got_base, n);
    chk("rden_total", rd_q.size() - rd_base, n);
    chk("outstanding_le_depth", max_out <= DEPTH, 1);
    for (int k = 0; k < n; k++) begin
      a = (sa + k) % NWORDS;
      if (rd_base + k < rd_q.size()) chk($sformatf("rd_addr[%0d]", k), rd_q[rd_base + k], a);
      if (got_base + k < got_q.size()) chk($sformatf("data[%0d]", k), got_q[got_base + k], mem[a]);
    end
    if (n == 0) chk("zero_done_cyc", done_cyc, e + 1);
    if (mode == 0 && n > 0 && got_cyc_q.size() > got_base) begin
      chk("first_xfer_cyc", got_cyc_q[got_base], e + 1 + LAT);
      chk("last_xfer_cyc", got_cyc_q[got_cyc_q.size() - 1], e + n + LAT);
      chk("done_cyc", done_cyc, e + n + LAT + 1);
    end
    if (mode == 1) chk("rden_before_release", rel_rd, DEPTH);
  endtask

  int base, dbase;

  initial begin
    bif.out_ready = 1'b0;
    for (int k = 0; k < NWORDS; k++) mem[k] = pat(k);

    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    do_run(0, 4, 0, 1'b0);
    do_run(126, 4, 0, 1'b0);

    for (int k = 0; k < NWORDS; k++) mem[k] = {8{$urandom()}};
    do_run(int'($urandom_range(0, NWORDS - 1)), 8, 1, 1'b0);
    do_run(int'($urandom_range(0, NWORDS - 1)), 16, 2, 1'b0);
    do_run(33, 0, 0, 1'b0);
    do_run(20, 8, 0, 1'b1);
    do_run(77, 128, 0, 1'b0);
    for (int i = 0; i < 4; i++)
      do_run(int'($urandom_range(0, NWORDS - 1)), int'($urandom_range(1, NWORDS)), 3, 1'b0);

    // reset asserted between clock edges after three transfers of an 8-word run
    base  = got_q.size();
    dbase = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; start_addr = AW'(40); word_count = CW'(8); bif.out_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk); #1;
      if (got_q.size() - base >= 3) break;
    end
    chk("mid_xfers", got_q.size() - base, 3);
    for (int k = 0; k < 3; k++)
      if (base + k < got_q.size()) chk($sformatf("mid_data[%0d]", k), got_q[base + k], mem[40 + k]);
    rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    repeat (3) @(posedge clk);
    #1 chk("held_busy", busy, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1 chk("no_done_after_reset", done_cnt - dbase, 0);
    chk("no_xfer_after_reset", got_q.size() - base, 3);

    do_run(5, 6, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
